// File: rtl/riscv_pkg.sv
// Shared instruction-fetch constants, the response record and the little-endian
// word-assembly rule used by both the storage and the fetch front end.
package riscv_pkg;

    localparam int unsigned IMEM_DEPTH_BYTES = 256;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] inst;
    } fetch_rsp_t;

    function automatic logic [31:0] assemble_word(input logic [7:0] b0, input logic [7:0] b1,
                                                  input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

endpackage

// File: rtl/imem_bytes.sv
// Byte-organised instruction storage with one word write port and one
// combinational word read port; callers guarantee aligned, in-range indices.
module imem_bytes
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES
) (
    input  logic                           clk,
    input  logic                           wr_en_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] wr_idx_i,
    input  logic [31:0]                    wr_data_i,
    input  logic [$clog2(DEPTH_BYTES)-1:0] rd_idx_i,
    output logic [31:0]                    rd_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

    logic [7:0] mem_q [DEPTH_BYTES];

    // NOTE: the array has no reset on purpose; program contents must survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i]              <= wr_data_i[7:0];
            mem_q[wr_idx_i + IDX_W'(1)]  <= wr_data_i[15:8];
            mem_q[wr_idx_i + IDX_W'(2)]  <= wr_data_i[23:16];
            mem_q[wr_idx_i + IDX_W'(3)]  <= wr_data_i[31:24];
        end
    end

    assign rd_data_o = assemble_word(mem_q[rd_idx_i],
                                     mem_q[rd_idx_i + IDX_W'(1)],
                                     mem_q[rd_idx_i + IDX_W'(2)],
                                     mem_q[rd_idx_i + IDX_W'(3)]);

endmodule

// File: rtl/inst_mem_fetch.sv
// Instruction fetch front end: valid/ready request handshake, one-deep registered
// response with fault reporting, flush, and a word-wide program port.
module inst_mem_fetch
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = IMEM_DEPTH_BYTES,
    parameter int unsigned ADDR_W      = 64,
    parameter logic [31:0] NOP_INST    = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_inst,
    output logic              rsp_fault,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic              prog_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data
);

    localparam int unsigned       IDX_W     = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - 4);

    function automatic logic word_ok(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
    endfunction

    fetch_rsp_t       rsp_d, rsp_q;
    logic             accept;
    logic             req_ok;
    logic             wr_en;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_data;

    assign req_ready = !prog_en && !flush && (!rsp_q.valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign req_ok    = word_ok(req_addr);
    assign rd_idx    = req_ok ? req_addr[IDX_W-1:0] : '0;
    // Reset wins over the program port, so a write in the reset cycle is dropped.
    assign wr_en     = prog_en && !reset && word_ok(prog_addr);

    imem_bytes #(.DEPTH_BYTES(DEPTH_BYTES)) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (prog_addr[IDX_W-1:0]),
        .wr_data_i (prog_data),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data)
    );

    // NOTE: rsp_d starts as a copy of rsp_q so every path assigns it and no latch forms.
    always_comb begin
        rsp_d = rsp_q;
        if (accept) begin
            rsp_d.valid = 1'b1;
            rsp_d.fault = !req_ok;
            rsp_d.inst  = req_ok ? rd_data : NOP_INST;
        end else if (flush || rsp_ready) begin
            rsp_d.valid = 1'b0;
        end
    end

    // NOTE: non-blocking assignment keeps the read above seeing pre-write storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q <= '{valid: 1'b0, fault: 1'b0, inst: NOP_INST};
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign rsp_valid = rsp_q.valid;
    assign rsp_inst  = rsp_q.inst;
    assign rsp_fault = rsp_q.fault;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Self-checking bench: word-level storage model plus transaction-level response model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_mem_fetch;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned WORDS  = DEPTH / 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_inst;
    logic              rsp_fault;
    logic              rsp_ready;
    logic              flush;
    logic              prog_en;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;

    int n_cmp  = 0;
    int n_fail = 0;

    inst_mem_fetch #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W), .NOP_INST(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_inst  (rsp_inst),
        .rsp_fault (rsp_fault),
        .rsp_ready (rsp_ready),
        .flush     (flush),
        .prog_en   (prog_en),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: word memory plus a single pending response slot.
    logic [31:0] model_mem [WORDS];
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] exp_inst;
    logic        model_ok = 1'b0;

    function automatic bit addr_good(input logic [ADDR_W-1:0] a);
        return (a % 4 == 0) && (a + 4 <= DEPTH);
    endfunction

    function automatic bit model_ready();
        return !prog_en && !flush && (!exp_valid || rsp_ready);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_valid = 1'b0;
            exp_fault = 1'b0;
            exp_inst  = NOP;
            model_ok  = 1'b1;
        end else if (model_ok) begin
            if (req_valid && model_ready()) begin
                exp_valid = 1'b1;
                exp_fault = !addr_good(req_addr);
                exp_inst  = exp_fault ? NOP : model_mem[req_addr / 4];
            end else if (flush || (exp_valid && rsp_ready)) begin
                exp_valid = 1'b0;
            end
            if (prog_en && addr_good(prog_addr)) model_mem[prog_addr / 4] = prog_data;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("req_ready", {31'd0, req_ready}, {31'd0, model_ready()});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("rsp_inst", rsp_inst, exp_inst);
                check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1; flush = 1'b0;
        prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic rdy);
        req_valid = 1'b1; req_addr = a; rsp_ready = rdy;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick(); tick();
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_inst", rsp_inst, NOP);
        check("reset_fault", {31'd0, rsp_fault}, 32'd0);
        reset = 1'b0;

        // Fill every word through the program port so all fetches are defined.
        for (int w = 0; w < int'(WORDS); w++) begin
            prog_en   = 1'b1;
            prog_addr = ADDR_W'(w * 4);
            prog_data = (w == 0) ? 32'h1000_0513 : (w == 1) ? 32'h0050_0293 : $urandom;
            tick();
        end
        idle();
        tick();

        // Back-to-back fetches.
        fetch(0, 1'b1); tick();
        check("b2b_first", rsp_inst, 32'h1000_0513);
        fetch(4, 1'b1); tick();
        check("b2b_second", rsp_inst, 32'h0050_0293);
        check("b2b_fault", {31'd0, rsp_fault}, 32'd0);
        idle(); tick();
        check("b2b_drain", {31'd0, rsp_valid}, 32'd0);

        // Stall holds the response and blocks new requests.
        fetch(4, 1'b0); tick();
        fetch(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_inst", rsp_inst, 32'h0050_0293);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        idle(); #1;
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("stall_release", {31'd0, rsp_valid}, 32'd0);

        // Faulting fetches leave storage intact.
        fetch(ADDR_W'('h102), 1'b1); tick();
        check("mis_fault", {31'd0, rsp_fault}, 32'd1);
        check("mis_inst", rsp_inst, NOP);
        fetch(ADDR_W'(DEPTH), 1'b1); tick();
        check("oor_fault", {31'd0, rsp_fault}, 32'd1);
        check("oor_inst", rsp_inst, NOP);
        fetch(0, 1'b1); tick();
        check("after_fault", rsp_inst, 32'h1000_0513);
        check("after_fault_flag", {31'd0, rsp_fault}, 32'd0);
        idle(); tick();

        // Program port has priority; new word visible on the next fetch.
        fetch(8, 1'b1);
        prog_en = 1'b1; prog_addr = 8; prog_data = 32'hCAFE_F00D; #1;
        check("prog_blocks_req", {31'd0, req_ready}, 32'd0);
        tick();
        prog_en = 1'b0; tick();
        check("prog_readback", rsp_inst, 32'hCAFE_F00D);
        idle(); tick();

        // Flush drops the held response and the concurrent request.
        fetch(4, 1'b0); tick();
        fetch(0, 1'b0); flush = 1'b1; #1;
        check("flush_ready", {31'd0, req_ready}, 32'd0);
        tick();
        idle();
        check("flush_valid", {31'd0, rsp_valid}, 32'd0);
        tick();

        // Reset during a stall loses the response but keeps storage.
        fetch(4, 1'b0); tick(); tick();
        reset = 1'b1; tick();
        check("rst_stall_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_stall_inst", rsp_inst, NOP);
        reset = 1'b0;
        fetch(0, 1'b1); tick();
        check("rst_keeps_mem", rsp_inst, 32'h1000_0513);
        idle(); tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel       = int'($urandom_range(0, 99));
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = (sel < 80) ? ADDR_W'($urandom_range(0, WORDS - 1) * 4)
                      : (sel < 90) ? ADDR_W'($urandom_range(0, DEPTH + 8))
                      : {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            prog_en   = ($urandom_range(0, 9) == 0);
            prog_addr = ($urandom_range(0, 4) != 0) ? ADDR_W'($urandom_range(0, WORDS - 1) * 4)
                                                    : ADDR_W'($urandom_range(0, DEPTH + 8));
            prog_data = $urandom;
            reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        idle();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
